// File: rtl/sync_pkg.sv
// Shared defaults and sizing helper for the multi-channel input conditioner.
package sync_pkg;

  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned FILTER_LEN_DEF  = 3;

  // Counter only needs to reach FILTER_LEN-1; keep at least one bit.
  function automatic int unsigned cnt_width(input int unsigned len);
    return (len < 2) ? 1 : $clog2(len);
  endfunction

endpackage

// File: rtl/sync_filter_ch.sv
// One channel: metastability chain, consecutive-sample glitch filter, level and edge pulses.
module sync_filter_ch
  import sync_pkg::*;
#(
  parameter int unsigned STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned FILTER_LEN = FILTER_LEN_DEF,
  parameter logic        RST_VAL    = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic change_next
);

  localparam int unsigned    CW       = cnt_width(FILTER_LEN);
  localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_LEN - 1);

  logic [STAGES-1:0] chain;
  logic [CW-1:0]     cnt;
  logic              cand;
  logic              update;

  assign cand = chain[STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) chain <= {STAGES{RST_VAL}};
    else     chain <= {chain[STAGES-2:0], async_in};
  end

  // The output flips only on the FILTER_LEN-th consecutive differing sample.
  always_comb begin
    update      = (cand != sync_out) && (cnt == CNT_LAST);
    change_next = update;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      sync_out   <= RST_VAL;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= update & cand;
      fall_pulse <= update & ~cand;
      if (cand == sync_out) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        sync_out <= cand;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sync_filter_multi.sv
// WIDTH independent conditioned channels plus a registered any-edge summary.
module sync_filter_multi
  import sync_pkg::*;
#(
  parameter int unsigned          WIDTH      = 4,
  parameter int unsigned          STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned          FILTER_LEN = FILTER_LEN_DEF,
  parameter logic [WIDTH-1:0]     RST_VAL    = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             any_change
);

  logic [WIDTH-1:0] change_next;

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    sync_filter_ch #(
      .STAGES     (STAGES),
      .FILTER_LEN (FILTER_LEN),
      .RST_VAL    (RST_VAL[g])
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .async_in    (async_in[g]),
      .sync_out    (sync_out[g]),
      .rise_pulse  (rise_pulse[g]),
      .fall_pulse  (fall_pulse[g]),
      .change_next (change_next[g])
    );
  end

  // Built from the channels' next-pulse terms so it lands on the same edge as the pulses.
  always_ff @(posedge clk) begin
    if (rst) any_change <= 1'b0;
    else     any_change <= |change_next;
  end

endmodule

// File: tb/tb_sync_filter_multi.sv
// Directed scenarios plus randomized traffic against a queue-based reference model.
module tb_sync_filter_multi;

  localparam int W  = 4;
  localparam int S  = 2;
  localparam int FL = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic [W-1:0] async_in = '0;
  logic [W-1:0] sync_out, rise_pulse, fall_pulse;
  logic         any_change;

  logic c_rst = 1'b1;
  logic c_in  = 1'b0;
  logic c_out, c_rise, c_fall, c_any;

  int checks = 0;
  int errors = 0;

  sync_filter_multi #(
    .WIDTH      (W),
    .STAGES     (S),
    .FILTER_LEN (FL),
    .RST_VAL    (4'hF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .async_in   (async_in),
    .sync_out   (sync_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .any_change (any_change)
  );

  sync_filter_multi #(
    .WIDTH      (1),
    .STAGES     (3),
    .FILTER_LEN (1),
    .RST_VAL    (1'b0)
  ) dut_c (
    .clk        (clk),
    .rst        (c_rst),
    .async_in   (c_in),
    .sync_out   (c_out),
    .rise_pulse (c_rise),
    .fall_pulse (c_fall),
    .any_change (c_any)
  );

  // Reference: queue of captured samples (front = newest) and a run length of
  // consecutive candidate samples that disagree with the reported level.
  logic [W-1:0] m_q[$];
  logic [W-1:0] m_cand, m_out, m_rise, m_fall;
  logic         m_any;
  int           m_run[W];

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      for (int k = 0; k < S; k++) m_q.push_back('1);
      m_out  = '1;
      m_rise = '0;
      m_fall = '0;
      m_any  = 1'b0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
    end else begin
      m_cand = m_q[S-1];
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < W; i++) begin
        if (m_cand[i] !== m_out[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == FL) begin
            m_out[i] = m_cand[i];
            if (m_cand[i]) m_rise[i] = 1'b1;
            else           m_fall[i] = 1'b1;
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_any = (m_rise | m_fall) != '0;
      void'(m_q.pop_back());
      m_q.push_front(async_in);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input logic [W-1:0] v);
    async_in = v;
    repeat (10) tick();
  endtask

  // Counts edges from the capture edge (edge 1) until any pulse shows; returns 0 if no pulse in the window.
  task automatic wait_pulse(output int n);
    n = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if ((rise_pulse | fall_pulse) != '0 || any_change) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int n;
    rst = 1'b1;
    async_in = 4'h0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (sync_out !== 4'hF || rise_pulse !== 4'h0 || fall_pulse !== 4'h0 || any_change !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: out=%h rise=%h fall=%h any=%b required out=F rise=0 fall=0 any=0",
                 sync_out, rise_pulse, fall_pulse, any_change);
      end
    end
    rst = 1'b0;
    wait_pulse(n);
    checks++;
    if (n != S + FL) begin
      errors++;
      $display("FAIL reset_latency: edges=%0d required %0d", n, S + FL);
    end
    checks++;
    if (sync_out !== 4'h0 || fall_pulse !== 4'hF || rise_pulse !== 4'h0 || any_change !== 1'b1) begin
      errors++;
      $display("FAIL reset_fall: out=%h rise=%h fall=%h any=%b required out=0 rise=0 fall=F any=1",
               sync_out, rise_pulse, fall_pulse, any_change);
    end
    tick();
    checks++;
    if (sync_out !== 4'h0 || fall_pulse !== 4'h0 || any_change !== 1'b0) begin
      errors++;
      $display("FAIL reset_one_cycle: out=%h fall=%h any=%b required out=0 fall=0 any=0",
               sync_out, fall_pulse, any_change);
    end
  endtask

  task automatic test_glitch;
    settle(4'hF);
    async_in = 4'hE;
    tick();
    tick();
    async_in = 4'hF;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (sync_out !== 4'hF || rise_pulse !== 4'h0 || fall_pulse !== 4'h0 || any_change !== 1'b0) begin
        errors++;
        $display("FAIL glitch_reject cyc %0d: out=%h rise=%h fall=%h any=%b required out=F no pulses",
                 k, sync_out, rise_pulse, fall_pulse, any_change);
      end
      tick();
    end
  endtask

  task automatic test_stable_edge;
    int n;
    settle(4'hF);
    async_in = 4'hB;
    wait_pulse(n);
    checks++;
    if (n != S + FL || sync_out !== 4'hB || fall_pulse !== 4'h4 || rise_pulse !== 4'h0) begin
      errors++;
      $display("FAIL stable_fall: edges=%0d out=%h rise=%h fall=%h required edges=%0d out=B rise=0 fall=4",
               n, sync_out, rise_pulse, fall_pulse, S + FL);
    end
    tick();
    checks++;
    if (fall_pulse !== 4'h0 || sync_out !== 4'hB) begin
      errors++;
      $display("FAIL stable_fall_width: out=%h fall=%h required out=B fall=0", sync_out, fall_pulse);
    end
    settle(4'hB);
    async_in = 4'hF;
    wait_pulse(n);
    checks++;
    if (n != S + FL || sync_out !== 4'hF || rise_pulse !== 4'h4 || fall_pulse !== 4'h0) begin
      errors++;
      $display("FAIL stable_rise: edges=%0d out=%h rise=%h fall=%h required edges=%0d out=F rise=4 fall=0",
               n, sync_out, rise_pulse, fall_pulse, S + FL);
    end
  endtask

  task automatic test_simultaneous;
    int n;
    settle(4'hF);
    async_in = 4'h6;
    wait_pulse(n);
    checks++;
    if (n != S + FL || sync_out !== 4'h6 || fall_pulse !== 4'h9 || any_change !== 1'b1) begin
      errors++;
      $display("FAIL simul_fall: edges=%0d out=%h fall=%h any=%b required edges=%0d out=6 fall=9 any=1",
               n, sync_out, fall_pulse, any_change, S + FL);
    end
    tick();
    checks++;
    if (any_change !== 1'b0 || fall_pulse !== 4'h0) begin
      errors++;
      $display("FAIL simul_single_any: any=%b fall=%h required any=0 fall=0", any_change, fall_pulse);
    end
  endtask

  task automatic test_reset_mid_filter;
    int n;
    settle(4'hF);
    async_in = 4'hD;
    repeat (S + FL - 1) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (sync_out !== 4'hF || fall_pulse !== 4'h0 || any_change !== 1'b0) begin
      errors++;
      $display("FAIL midfilter_reset: out=%h fall=%h any=%b required out=F fall=0 any=0",
               sync_out, fall_pulse, any_change);
    end
    rst = 1'b0;
    wait_pulse(n);
    checks++;
    if (n != S + FL || sync_out !== 4'hD || fall_pulse !== 4'h2) begin
      errors++;
      $display("FAIL midfilter_restart: edges=%0d out=%h fall=%h required edges=%0d out=D fall=2",
               n, sync_out, fall_pulse, S + FL);
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 59) == 0);
      async_in = async_in ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      tick();
      checks++;
      if (sync_out !== m_out || rise_pulse !== m_rise || fall_pulse !== m_fall || any_change !== m_any) begin
        errors++;
        $display("FAIL random cyc %0d: out=%h rise=%h fall=%h any=%b required out=%h rise=%h fall=%h any=%b",
                 k, sync_out, rise_pulse, fall_pulse, any_change, m_out, m_rise, m_fall, m_any);
      end
      checks++;
      if ((rise_pulse & fall_pulse) != '0) begin
        errors++;
        $display("FAIL random_exclusive cyc %0d: rise=%h fall=%h required no overlap", k, rise_pulse, fall_pulse);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_corner;
    int n;
    int highs, rises, falls;
    c_rst = 1'b1;
    c_in  = 1'b0;
    tick();
    tick();
    checks++;
    if (c_out !== 1'b0 || c_rise !== 1'b0 || c_fall !== 1'b0 || c_any !== 1'b0) begin
      errors++;
      $display("FAIL corner_reset: out=%b rise=%b fall=%b any=%b required all 0", c_out, c_rise, c_fall, c_any);
    end
    c_rst = 1'b0;
    repeat (6) tick();
    c_in = 1'b1;
    n = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (c_rise || c_fall || c_any) begin
        n = k;
        break;
      end
    end
    checks++;
    if (n != 4 || c_out !== 1'b1 || c_rise !== 1'b1 || c_fall !== 1'b0 || c_any !== 1'b1) begin
      errors++;
      $display("FAIL corner_rise: edges=%0d out=%b rise=%b fall=%b any=%b required edges=4 out=1 rise=1 fall=0 any=1",
               n, c_out, c_rise, c_fall, c_any);
    end
    tick();
    checks++;
    if (c_rise !== 1'b0 || c_out !== 1'b1) begin
      errors++;
      $display("FAIL corner_rise_width: out=%b rise=%b required out=1 rise=0", c_out, c_rise);
    end
    c_in = 1'b0;
    repeat (8) tick();
    c_in = 1'b1;
    tick();
    c_in = 1'b0;
    highs = 0;
    rises = 0;
    falls = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      highs += int'(c_out);
      rises += int'(c_rise);
      falls += int'(c_fall);
    end
    checks++;
    if (highs != 1 || rises != 1 || falls != 1) begin
      errors++;
      $display("FAIL corner_short_pulse: high_cycles=%0d rises=%0d falls=%0d required 1 1 1", highs, rises, falls);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_glitch();
    test_stable_edge();
    test_simultaneous();
    test_reset_mid_filter();
    test_random();
    test_corner();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
